// File: rtl/light_bcd_conv.sv
// rtl/light_bcd_conv.sv - 8-bit light sample to 4-digit BCD via sequential double dabble
// Optional LIGHT_AVG4_EN: convert the 4-sample running average instead of the raw sample.
`timescale 1ns/1ps
module light_bcd_conv #(
  parameter int unsigned UPDATE_HOLD = 0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned HOLD_W = (UPDATE_HOLD > 0) ? $clog2(UPDATE_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AVG  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef LIGHT_AVG4_EN
  localparam state_t START_STATE = AVG;
`else
  localparam state_t START_STATE = CONV;
`endif

  state_t              state;
  state_t              state_nxt;
  logic [19:0]         shreg;
  logic [2:0]          iter;
  logic [HOLD_W-1:0]   hold;
  logic                pend_full;
  logic [7:0]          pend_data;
  logic                start;
  logic                chain;
  logic                pend_consume;
  logic                to_pend;
  logic                overrun_set;
  logic [7:0]          operand;

  // One shift-add-3 step over {bcd[11:0], bin[7:0]}.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5)
        t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Pending sample wins over a fresh strobe; a strobe that does not start goes to pending.
  always_comb begin
    chain        = (state == DONE) && pend_full && (UPDATE_HOLD == 0);
    start        = ((state == IDLE) && (hold == '0) && (pend_full || sample_valid)) || chain;
    operand      = pend_full ? pend_data : sample_in;
    pend_consume = start && pend_full;
    to_pend      = sample_valid && !(start && !pend_full);
    overrun_set  = to_pend && pend_full && !pend_consume;
  end

  always_ff @(posedge clk_in) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = START_STATE;
      AVG:  state_nxt = CONV;
      CONV: if (iter == 3'd7) state_nxt = DONE;
      DONE: state_nxt = chain ? START_STATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

`ifdef LIGHT_AVG4_EN
  // The current operand is the fourth history entry, so only the three older ones are stored.
  logic [7:0] hist [3];
  logic [7:0] avg_q;
  logic [9:0] avg_sum;

  assign avg_sum = 10'(operand) + 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      avg_q   <= '0;
    end else if (start) begin
      hist[0] <= operand;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      avg_q   <= avg_sum[9:2];
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      shreg     <= '0;
      iter      <= '0;
      hold      <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      pend_full <= 1'b0;
      pend_data <= '0;
      overrun   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (hold != '0)
        hold <= hold - HOLD_W'(1);

`ifdef LIGHT_AVG4_EN
      if (state == AVG) begin
        shreg <= {12'h000, avg_q};
        iter  <= '0;
      end else if (state == CONV) begin
        shreg <= dd_step(shreg);
        iter  <= iter + 3'd1;
      end
`else
      if (start) begin
        shreg <= {12'h000, operand};
        iter  <= '0;
      end else if (state == CONV) begin
        shreg <= dd_step(shreg);
        iter  <= iter + 3'd1;
      end
`endif

      if (state == DONE) begin
        bcd_out   <= {4'h0, shreg[19:8]};
        bcd_valid <= 1'b1;
        hold      <= HOLD_W'(UPDATE_HOLD);
      end

      if (to_pend) begin
        pend_full <= 1'b1;
        pend_data <= sample_in;
      end else if (pend_consume) begin
        pend_full <= 1'b0;
      end

      if (overrun_set)
        overrun <= 1'b1;
    end
  end

endmodule
